// File: rtl/udp_tx_noc_in.sv
// UDP TX ingress: splits one NoC0 message (header, metadata, payload flits) into a
// metadata handshake and a payload stream, flagging NoC flit counts that disagree with the UDP length.
//   state    | meaning
//   HDR      | waiting for a header flit
//   META_IN  | waiting for the metadata flit
//   META_OUT | presenting metadata to the engine
//   DATA     | payload pass-through until the NoC flit count runs out
module udp_tx_noc_in #(
  parameter int NOC_DATA_W = 512,
  parameter int DATA_BYTES = NOC_DATA_W / 8,
  parameter int PAD_W      = $clog2(DATA_BYTES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  noc0_ctovr_udp_tx_in_val,
  input  logic [NOC_DATA_W-1:0] noc0_ctovr_udp_tx_in_data,
  output logic                  udp_tx_in_noc0_ctovr_rdy,
  output logic                  udp_tx_meta_val,
  output logic [31:0]           udp_tx_meta_src_ip,
  output logic [31:0]           udp_tx_meta_dst_ip,
  output logic [15:0]           udp_tx_meta_src_port,
  output logic [15:0]           udp_tx_meta_dst_port,
  output logic [15:0]           udp_tx_meta_data_length,
  input  logic                  udp_tx_meta_rdy,
  output logic                  udp_tx_data_val,
  output logic [NOC_DATA_W-1:0] udp_tx_data,
  output logic                  udp_tx_data_last,
  output logic [PAD_W-1:0]      udp_tx_data_padbytes,
  input  logic                  udp_tx_data_rdy,
  output logic                  udp_tx_err_len_mismatch
);

  typedef enum logic [1:0] {HDR, META_IN, META_OUT, DATA} state_t;

  state_t           state, state_next;
  logic [7:0]       msg_len_q;
  logic [7:0]       data_cnt;
  logic [PAD_W-1:0] pad_q;
  logic             err_q;

  logic             in_hs;
  logic [7:0]       hdr_len;
  logic [15:0]      in_len;
  logic [16:0]      exp_flits;
  logic [15:0]      len_rem;
  logic [PAD_W-1:0] pad_next;
  logic [7:0]       cnt_next;
  logic             mismatch;

  assign in_hs    = noc0_ctovr_udp_tx_in_val & udp_tx_in_noc0_ctovr_rdy;
  assign hdr_len  = noc0_ctovr_udp_tx_in_data[NOC_DATA_W-17 -: 8];
  assign in_len   = noc0_ctovr_udp_tx_in_data[NOC_DATA_W-97 -: 16];

  // 17-bit ceiling divide so a length near 64K cannot wrap
  assign exp_flits = ({1'b0, in_len} + 17'(DATA_BYTES - 1)) / 17'(DATA_BYTES);
  assign len_rem   = in_len % 16'(DATA_BYTES);
  assign pad_next  = (len_rem == 16'd0) ? '0 : PAD_W'(16'(DATA_BYTES) - len_rem);
  assign cnt_next  = msg_len_q - 8'd1;
  assign mismatch  = {9'd0, cnt_next} != exp_flits;

  assign udp_tx_err_len_mismatch = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= HDR;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next               = state;
    udp_tx_in_noc0_ctovr_rdy = 1'b0;
    udp_tx_meta_val          = 1'b0;
    udp_tx_data_val          = 1'b0;
    udp_tx_data              = '0;
    udp_tx_data_last         = 1'b0;
    udp_tx_data_padbytes     = '0;
    case (state)
      HDR: begin
        udp_tx_in_noc0_ctovr_rdy = 1'b1;
        if (noc0_ctovr_udp_tx_in_val && hdr_len != 8'd0) state_next = META_IN;
      end
      META_IN: begin
        udp_tx_in_noc0_ctovr_rdy = 1'b1;
        if (noc0_ctovr_udp_tx_in_val) state_next = META_OUT;
      end
      META_OUT: begin
        udp_tx_meta_val = 1'b1;
        if (udp_tx_meta_rdy) state_next = (data_cnt == 8'd0) ? HDR : DATA;
      end
      DATA: begin
        udp_tx_data_val          = noc0_ctovr_udp_tx_in_val;
        udp_tx_in_noc0_ctovr_rdy = udp_tx_data_rdy;
        udp_tx_data              = noc0_ctovr_udp_tx_in_data;
        udp_tx_data_last         = (data_cnt == 8'd1);
        udp_tx_data_padbytes     = (data_cnt == 8'd1) ? pad_q : '0;
        if (noc0_ctovr_udp_tx_in_val && udp_tx_data_rdy && data_cnt == 8'd1) state_next = HDR;
      end
      default: state_next = HDR;
    endcase
  end

  // err is registered, so both error sources pulse in the cycle after the offending flit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msg_len_q               <= '0;
      data_cnt                <= '0;
      pad_q                   <= '0;
      err_q                   <= 1'b0;
      udp_tx_meta_src_ip      <= '0;
      udp_tx_meta_dst_ip      <= '0;
      udp_tx_meta_src_port    <= '0;
      udp_tx_meta_dst_port    <= '0;
      udp_tx_meta_data_length <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        HDR: begin
          if (in_hs) begin
            msg_len_q <= hdr_len;
            if (hdr_len == 8'd0) err_q <= 1'b1;
          end
        end
        META_IN: begin
          if (in_hs) begin
            udp_tx_meta_src_ip      <= noc0_ctovr_udp_tx_in_data[NOC_DATA_W-1  -: 32];
            udp_tx_meta_dst_ip      <= noc0_ctovr_udp_tx_in_data[NOC_DATA_W-33 -: 32];
            udp_tx_meta_src_port    <= noc0_ctovr_udp_tx_in_data[NOC_DATA_W-65 -: 16];
            udp_tx_meta_dst_port    <= noc0_ctovr_udp_tx_in_data[NOC_DATA_W-81 -: 16];
            udp_tx_meta_data_length <= in_len;
            data_cnt                <= cnt_next;
            pad_q                   <= pad_next;
            err_q                   <= mismatch;
          end
        end
        DATA: begin
          if (in_hs) data_cnt <= data_cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
